wavegen_mc: RTL and testbench

WAVEGEN_MC -- requirements
Module: wavegen_mc

---
 rtl/wavegen_mc_if.sv | 25 ++
 rtl/wavegen_mc.sv | 184 ++++++++++++++++++
 tb/tb_wavegen_mc.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wavegen_mc_if.sv
// Bus bundle for wavegen_mc: per-channel config writes, sync pulse and the
// time-multiplexed sample output.
interface wavegen_mc_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned OW  = 12
);
  logic              cfg_we;
  logic [3:0]        cfg_ch;
  logic [2:0]        cfg_addr;
  logic [31:0]       cfg_data;
  logic              sync;
  logic [NCH*OW-1:0] out_flat;
  logic              out_valid;
  logic [3:0]        out_ch;

  modport master (
    output cfg_we, cfg_ch, cfg_addr, cfg_data, sync,
    input  out_flat, out_valid, out_ch
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_addr, cfg_data, sync,
    output out_flat, out_valid, out_ch
  );
endinterface

// File: rtl/wavegen_mc.sv
// Multi-channel waveform generator: per-channel phase accumulators feeding one
// time-shared shape / gain / offset / saturate pipeline.
module wavegen_mc #(
  parameter int unsigned NCH = 4,
  parameter int unsigned PW  = 16,
  parameter int unsigned OW  = 12,
  parameter int unsigned DW  = 8
) (
  input logic         clk,
  input logic         rst,
  wavegen_mc_if.slave bus
);
  localparam int unsigned SW  = 4;
  localparam int unsigned CW  = OW + 1;
  localparam int unsigned PRW = 2 * OW + 2;
  localparam int unsigned YW  = PRW + 1;
  localparam logic [OW-1:0]        MID  = {1'b1, {(OW-1){1'b0}}};
  localparam logic [OW-1:0]        FULL = '1;
  localparam logic signed [YW-1:0] YMAX = YW'(FULL);

  logic [PW-1:0] step_r  [NCH];
  logic [DW-1:0] pre_r   [NCH];
  logic [OW-1:0] gain_r  [NCH];
  logic [OW-1:0] ofs_r   [NCH];
  logic [OW-1:0] duty_r  [NCH];
  logic [1:0]    mode_r  [NCH];
  logic          en_r    [NCH];
  logic [PW-1:0] phase_r [NCH];
  logic [DW-1:0] pc_r    [NCH];

  logic [SW-1:0] slot;
  logic [OW:0]   cur_top;
  logic [1:0]    cur_mode;
  logic [OW-1:0] cur_duty, cur_gain, cur_ofs, shape;

  logic          s1_v, s2_v;
  logic [SW-1:0] s1_ch, s2_ch;
  logic [OW-1:0] s1_shape, s1_gain, s1_ofs, s2_y;

  logic signed [CW-1:0]  ctr;
  logic signed [PRW-1:0] prod;
  logic signed [YW-1:0]  y;
  logic [OW-1:0]         y_sat;

  logic [NCH*OW-1:0] out_r;
  logic              ov_r;
  logic [SW-1:0]     och_r;

  // Upper data bits beyond each register's width are don't-care
  logic unused_cfg;
  assign unused_cfg = ^bus.cfg_data;

  // Config registers and phase accumulators; sync beats a phase write beats accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        step_r[c]  <= '0;
        pre_r[c]   <= '0;
        gain_r[c]  <= MID;
        ofs_r[c]   <= MID;
        duty_r[c]  <= MID;
        mode_r[c]  <= '0;
        en_r[c]    <= 1'b0;
        phase_r[c] <= '0;
        pc_r[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.cfg_we && bus.cfg_ch == SW'(c)) begin
          case (bus.cfg_addr)
            3'd0: step_r[c] <= bus.cfg_data[PW-1:0];
            3'd1: pre_r[c]  <= bus.cfg_data[DW-1:0];
            3'd2: gain_r[c] <= bus.cfg_data[OW-1:0];
            3'd3: ofs_r[c]  <= bus.cfg_data[OW-1:0];
            3'd4: duty_r[c] <= bus.cfg_data[OW-1:0];
            3'd5: begin
              en_r[c]   <= bus.cfg_data[2];
              mode_r[c] <= bus.cfg_data[1:0];
            end
            default: ;
          endcase
        end
        if (bus.sync) begin
          phase_r[c] <= '0;
          pc_r[c]    <= '0;
        end else if (bus.cfg_we && bus.cfg_ch == SW'(c) && bus.cfg_addr == 3'd6) begin
          phase_r[c] <= bus.cfg_data[PW-1:0];
          pc_r[c]    <= '0;
        end else if (!en_r[c]) begin
          phase_r[c] <= '0;
          pc_r[c]    <= '0;
        end else if (pc_r[c] >= pre_r[c]) begin
          phase_r[c] <= phase_r[c] + step_r[c];
          pc_r[c]    <= '0;
        end else begin
          pc_r[c]    <= pc_r[c] + DW'(1);
        end
      end
    end
  end

  // Select the channel owning the current slot; only the phase MSBs matter
  always_comb begin
    cur_top  = '0;
    cur_mode = '0;
    cur_duty = '0;
    cur_gain = '0;
    cur_ofs  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (slot == SW'(c)) begin
        cur_top  = phase_r[c][PW-1 -: OW+1];
        cur_mode = mode_r[c];
        cur_duty = duty_r[c];
        cur_gain = gain_r[c];
        cur_ofs  = ofs_r[c];
      end
    end
  end

  always_comb begin
    shape = MID;
    case (cur_mode)
      2'd1:    shape = cur_top[OW:1];
      2'd2:    shape = cur_top[OW] ? ~cur_top[OW-1:0] : cur_top[OW-1:0];
      2'd3:    shape = (cur_top[OW:1] < cur_duty) ? FULL : '0;
      default: shape = MID;
    endcase
  end

  // Centre, scale (MID is unity), offset and clamp with headroom for every intermediate
  always_comb begin
    ctr  = $signed({1'b0, s1_shape}) - $signed({1'b0, MID});
    prod = PRW'(ctr) * PRW'($signed({1'b0, s1_gain}));
    y    = YW'(prod >>> (OW - 1)) + YW'($signed({1'b0, s1_ofs}));
    if (y[YW-1]) begin
      y_sat = '0;
    end else if (y > YMAX) begin
      y_sat = FULL;
    end else begin
      y_sat = y[OW-1:0];
    end
  end

  // Slot counter and three-stage sample pipeline; gain/offset ride along with the shape
  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= '0;
      s1_v     <= 1'b0;
      s1_ch    <= '0;
      s1_shape <= '0;
      s1_gain  <= '0;
      s1_ofs   <= '0;
      s2_v     <= 1'b0;
      s2_ch    <= '0;
      s2_y     <= '0;
      out_r    <= '0;
      ov_r     <= 1'b0;
      och_r    <= '0;
    end else begin
      slot     <= (slot == SW'(NCH - 1)) ? '0 : slot + SW'(1);
      s1_v     <= 1'b1;
      s1_ch    <= slot;
      s1_shape <= shape;
      s1_gain  <= cur_gain;
      s1_ofs   <= cur_ofs;
      s2_v     <= s1_v;
      s2_ch    <= s1_ch;
      s2_y     <= y_sat;
      ov_r     <= s2_v;
      if (s2_v) begin
        och_r <= s2_ch;
      end
      for (int c = 0; c < NCH; c++) begin
        if (s2_v && s2_ch == SW'(c)) begin
          out_r[c*OW +: OW] <= s2_y;
        end
      end
    end
  end

  assign bus.out_flat  = out_r;
  assign bus.out_valid = ov_r;
  assign bus.out_ch    = och_r;
endmodule

// File: tb/tb_wavegen_mc.sv
// Scoreboard bench for wavegen_mc: a cycle model queues each slot sample with
// its due cycle; scenario tasks pop and compare as the DUT emits samples.
module tb_wavegen_mc;
  localparam int unsigned NCH = 4;
  localparam int unsigned PW  = 16;
  localparam int unsigned OW  = 12;
  localparam int unsigned DW  = 8;

  typedef struct { int ch; int val; int due; int t; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wavegen_mc_if #(.NCH(NCH), .OW(OW)) bus ();
  wavegen_mc #(.NCH(NCH), .PW(PW), .OW(OW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_slot;
  int m_phase[NCH], m_pc[NCH], m_step[NCH], m_pre[NCH], m_gain[NCH];
  int m_ofs[NCH], m_duty[NCH], m_mode[NCH], m_en[NCH], m_out[NCH];

  // Expected sample value of channel c from its current model phase and config
  function automatic int model_sample(int c);
    int p, u, s, prod, sh, yv;
    p = m_phase[c];
    u = p >> 4;
    case (m_mode[c])
      0:       s = 2048;
      1:       s = u;
      2:       s = (p >= 32768) ? 4095 - ((p >> 3) & 4095) : ((p >> 3) & 4095);
      default: s = (u < m_duty[c]) ? 4095 : 0;
    endcase
    prod = (s - 2048) * m_gain[c];
    sh   = (prod >= 0) ? prod / 2048 : -((-prod + 2047) / 2048);
    yv   = sh + m_ofs[c];
    if (yv < 0) yv = 0;
    else if (yv > 4095) yv = 4095;
    return yv;
  endfunction

  function automatic logic [NCH*OW-1:0] exp_flat();
    logic [NCH*OW-1:0] f;
    f = '0;
    for (int c = 0; c < NCH; c++) f[c*OW +: OW] = OW'(m_out[c]);
    return f;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_phase[c] = 0; m_pc[c] = 0; m_step[c] = 0; m_pre[c] = 0;
      m_gain[c] = 2048; m_ofs[c] = 2048; m_duty[c] = 2048;
      m_mode[c] = 0; m_en[c] = 0; m_out[c] = 0;
    end
    m_slot = 0;
    sb.delete();
  endtask

  // Drive one cycle of inputs, advance the model, clock, and return at the negedge
  task automatic tick(input logic r, input logic we, input int ch, input int addr,
                      input int data, input logic sy);
    exp_t e;
    rst          = r;
    bus.cfg_we   = we;
    bus.cfg_ch   = 4'(ch);
    bus.cfg_addr = 3'(addr);
    bus.cfg_data = 32'(data);
    bus.sync     = sy;
    if (r) begin
      model_reset();
    end else begin
      e.ch = m_slot; e.val = model_sample(m_slot); e.due = cyc + 3; e.t = cyc;
      sb.push_back(e);
      for (int c = 0; c < NCH; c++) begin
        if (sy) begin
          m_phase[c] = 0; m_pc[c] = 0;
        end else if (we && ch == c && addr == 6) begin
          m_phase[c] = data & 65535; m_pc[c] = 0;
        end else if (m_en[c] == 0) begin
          m_phase[c] = 0; m_pc[c] = 0;
        end else if (m_pc[c] >= m_pre[c]) begin
          m_phase[c] = (m_phase[c] + m_step[c]) & 65535; m_pc[c] = 0;
        end else begin
          m_pc[c] = m_pc[c] + 1;
        end
      end
      if (we && ch < NCH) begin
        case (addr)
          0: m_step[ch] = data & 65535;
          1: m_pre[ch]  = data & 255;
          2: m_gain[ch] = data & 4095;
          3: m_ofs[ch]  = data & 4095;
          4: m_duty[ch] = data & 4095;
          5: begin m_en[ch] = (data >> 2) & 1; m_mode[ch] = data & 3; end
          default: ;
        endcase
      end
      m_slot = (m_slot + 1) % NCH;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 0, 0, 0, 1'b0);
    tick(1'b1, 1'b0, 0, 0, 0, 1'b0);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b, want 0", bus.out_valid);
    end
    n_tests++;
    if (bus.out_flat !== '0) begin
      n_fail++; $display("FAIL reset_flat: got %h, want 0", bus.out_flat);
    end
    n_tests++;
    if (bus.out_ch !== 4'd0) begin
      n_fail++; $display("FAIL reset_ch: got %0d, want 0", bus.out_ch);
    end
  endtask

  task automatic test_idle();
    exp_t e;
    int first = -1;
    int rel   = cyc;
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, 1'b0, 0, 0, 0, 1'b0);
      if (first < 0 && bus.out_valid === 1'b1) begin
        first = cyc - rel;
        n_tests++;
        if (bus.out_ch !== 4'd0) begin
          n_fail++; $display("FAIL idle_first_ch: got %0d, want 0", bus.out_ch);
        end
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        m_out[e.ch] = e.val;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 4'(e.ch) || bus.out_flat !== exp_flat()) begin
          n_fail++;
          $display("FAIL idle_sample cyc=%0d: valid=%b ch=%0d flat=%h, want valid=1 ch=%0d flat=%h",
                   cyc, bus.out_valid, bus.out_ch, bus.out_flat, e.ch, exp_flat());
        end
        n_tests++;
        if (bus.out_flat[e.ch*OW +: OW] !== 12'd2048) begin
          n_fail++; $display("FAIL idle_level ch=%0d: got %0d, want 2048", e.ch, bus.out_flat[e.ch*OW +: OW]);
        end
      end else if (bus.out_valid !== 1'b0) begin
        n_tests++; n_fail++;
        $display("FAIL idle_extra cyc=%0d: out_valid=%b ch=%0d, want none", cyc, bus.out_valid, bus.out_ch);
      end
    end
    n_tests++;
    if (first != 3) begin
      n_fail++; $display("FAIL idle_latency: first out_valid after %0d edges, want 3", first);
    end
  endtask

  task automatic test_ignored_writes();
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      case (k)
        0:       tick(1'b0, 1'b1, 4,  5, 5,       1'b0);
        1:       tick(1'b0, 1'b1, 15, 0, 'h1000,  1'b0);
        2:       tick(1'b0, 1'b1, 0,  7, 5,       1'b0);
        3:       tick(1'b0, 1'b1, 1,  7, 'hFFFF,  1'b0);
        default: tick(1'b0, 1'b0, 0,  0, 0,       1'b0);
      endcase
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        m_out[e.ch] = e.val;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 4'(e.ch) || bus.out_flat !== exp_flat()) begin
          n_fail++;
          $display("FAIL ignore_sample cyc=%0d: valid=%b ch=%0d flat=%h, want valid=1 ch=%0d flat=%h",
                   cyc, bus.out_valid, bus.out_ch, bus.out_flat, e.ch, exp_flat());
        end
        n_tests++;
        if (bus.out_flat[e.ch*OW +: OW] !== 12'd2048) begin
          n_fail++; $display("FAIL ignore_level ch=%0d: got %0d, want 2048", e.ch, bus.out_flat[e.ch*OW +: OW]);
        end
      end else if (bus.out_valid !== 1'b0) begin
        n_tests++; n_fail++;
        $display("FAIL ignore_extra cyc=%0d: out_valid=%b ch=%0d, want none", cyc, bus.out_valid, bus.out_ch);
      end
    end
  endtask

  task automatic test_sawtooth();
    exp_t e;
    int en_cyc = 1 << 30;
    int want;
    for (int k = 0; k < 48; k++) begin
      case (k)
        0:       tick(1'b0, 1'b1, 0, 0, 'h1000, 1'b0);
        1:       tick(1'b0, 1'b1, 0, 1, 0,      1'b0);
        2:       begin tick(1'b0, 1'b1, 0, 5, 5, 1'b0); en_cyc = cyc; end
        default: tick(1'b0, 1'b0, 0, 0, 0,      1'b0);
      endcase
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        m_out[e.ch] = e.val;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 4'(e.ch) || bus.out_flat !== exp_flat()) begin
          n_fail++;
          $display("FAIL saw_sample cyc=%0d: valid=%b ch=%0d flat=%h, want valid=1 ch=%0d flat=%h",
                   cyc, bus.out_valid, bus.out_ch, bus.out_flat, e.ch, exp_flat());
        end
        // One accumulation of 0x1000 per edge after enable: u advances 256 per cycle
        want = (e.ch == 0 && e.t >= en_cyc) ? (256 * (e.t - en_cyc)) % 4096 : 2048;
        n_tests++;
        if (int'(bus.out_flat[e.ch*OW +: OW]) != want) begin
          n_fail++; $display("FAIL saw_level ch=%0d: got %0d, want %0d", e.ch, bus.out_flat[e.ch*OW +: OW], want);
        end
      end else if (bus.out_valid !== 1'b0) begin
        n_tests++; n_fail++;
        $display("FAIL saw_extra cyc=%0d: out_valid=%b ch=%0d, want none", cyc, bus.out_valid, bus.out_ch);
      end
    end
  endtask

  task automatic test_triangle();
    exp_t e;
    int tq[$];
    int mx = -1;
    int mn = 1 << 20;
    int bad = 0;
    for (int k = 0; k < 1100; k++) begin
      case (k)
        0:       tick(1'b0, 1'b1, 1, 0, 'h100, 1'b0);
        1:       tick(1'b0, 1'b1, 1, 1, 3,     1'b0);
        2:       tick(1'b0, 1'b1, 1, 5, 6,     1'b0);
        default: tick(1'b0, 1'b0, 0, 0, 0,     1'b0);
      endcase
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        m_out[e.ch] = e.val;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 4'(e.ch) || bus.out_flat !== exp_flat()) begin
          n_fail++;
          $display("FAIL tri_sample cyc=%0d: valid=%b ch=%0d flat=%h, want valid=1 ch=%0d flat=%h",
                   cyc, bus.out_valid, bus.out_ch, bus.out_flat, e.ch, exp_flat());
        end
        if (e.ch == 1 && k >= 16) begin
          tq.push_back(int'(bus.out_flat[OW +: OW]));
          if (tq[$] > mx) mx = tq[$];
          if (tq[$] < mn) mn = tq[$];
        end
      end else if (bus.out_valid !== 1'b0) begin
        n_tests++; n_fail++;
        $display("FAIL tri_extra cyc=%0d: out_valid=%b ch=%0d, want none", cyc, bus.out_valid, bus.out_ch);
      end
    end
    n_tests++;
    if (mx < 4094 || mn != 0) begin
      n_fail++; $display("FAIL tri_range: got max=%0d min=%0d, want max>=4094 min=0", mx, mn);
    end
    // ch1 is sampled every 4 cycles, so 256 samples span one 1024-cycle period
    for (int j = 0; j + 256 < tq.size(); j++) if (tq[j] != tq[j+256]) bad++;
    n_tests++;
    if (bad != 0 || tq.size() < 260) begin
      n_fail++; $display("FAIL tri_period: got %0d mismatches over %0d samples, want 0", bad, tq.size());
    end
  endtask

  task automatic test_square();
    exp_t e;
    int hi = 0, lo = 0, other = 0, v;
    for (int k = 0; k < 280; k++) begin
      case (k)
        0:       tick(1'b0, 1'b1, 2, 4, 1024,  1'b0);
        1:       tick(1'b0, 1'b1, 2, 2, 4095,  1'b0);
        2:       tick(1'b0, 1'b1, 2, 3, 2048,  1'b0);
        3:       tick(1'b0, 1'b1, 2, 0, 'h400, 1'b0);
        4:       tick(1'b0, 1'b1, 2, 5, 7,     1'b0);
        default: tick(1'b0, 1'b0, 0, 0, 0,     1'b0);
      endcase
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        m_out[e.ch] = e.val;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 4'(e.ch) || bus.out_flat !== exp_flat()) begin
          n_fail++;
          $display("FAIL sq_sample cyc=%0d: valid=%b ch=%0d flat=%h, want valid=1 ch=%0d flat=%h",
                   cyc, bus.out_valid, bus.out_ch, bus.out_flat, e.ch, exp_flat());
        end
        if (e.ch == 2 && k >= 24) begin
          v = int'(bus.out_flat[2*OW +: OW]);
          if (v == 4095) hi++;
          else if (v == 0) lo++;
          else other++;
        end
      end else if (bus.out_valid !== 1'b0) begin
        n_tests++; n_fail++;
        $display("FAIL sq_extra cyc=%0d: out_valid=%b ch=%0d, want none", cyc, bus.out_valid, bus.out_ch);
      end
    end
    n_tests++;
    if (hi != 16 || lo != 48 || other != 0) begin
      n_fail++; $display("FAIL sq_duty: got hi=%0d lo=%0d other=%0d, want hi=16 lo=48 other=0", hi, lo, other);
    end
  endtask

  task automatic test_sync_phase();
    exp_t e;
    int mark1 = 1 << 30, mark2 = 1 << 30;
    bit seen1 = 0, seen2 = 0;
    for (int k = 0; k < 34; k++) begin
      case (k)
        0:       tick(1'b0, 1'b1, 0, 0, 0, 1'b0);
        8:       begin mark1 = cyc; tick(1'b0, 1'b1, 0, 6, 'h8000, 1'b0); end
        20:      begin mark2 = cyc; tick(1'b0, 1'b1, 0, 6, 'h8000, 1'b1); end
        default: tick(1'b0, 1'b0, 0, 0, 0, 1'b0);
      endcase
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        m_out[e.ch] = e.val;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 4'(e.ch) || bus.out_flat !== exp_flat()) begin
          n_fail++;
          $display("FAIL sync_sample cyc=%0d: valid=%b ch=%0d flat=%h, want valid=1 ch=%0d flat=%h",
                   cyc, bus.out_valid, bus.out_ch, bus.out_flat, e.ch, exp_flat());
        end
        if (e.ch == 0 && e.t > mark2 && !seen2) begin
          seen2 = 1; n_tests++;
          if (bus.out_flat[0 +: OW] !== 12'd0) begin
            n_fail++; $display("FAIL sync_wins: ch0 got %0d, want 0", bus.out_flat[0 +: OW]);
          end
        end else if (e.ch == 0 && e.t > mark1 && !seen1) begin
          seen1 = 1; n_tests++;
          if (bus.out_flat[0 +: OW] !== 12'd2048) begin
            n_fail++; $display("FAIL phase_write: ch0 got %0d, want 2048", bus.out_flat[0 +: OW]);
          end
        end
      end else if (bus.out_valid !== 1'b0) begin
        n_tests++; n_fail++;
        $display("FAIL sync_extra cyc=%0d: out_valid=%b ch=%0d, want none", cyc, bus.out_valid, bus.out_ch);
      end
    end
    n_tests++;
    if (!(seen1 && seen2)) begin
      n_fail++; $display("FAIL sync_seen: got seen1=%0d seen2=%0d, want 1 1", seen1, seen2);
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    int first = -1;
    int rel = 0;
    for (int k = 0; k < 28; k++) begin
      if (k == 5) begin
        tick(1'b1, 1'b0, 0, 0, 0, 1'b0);
        rel = cyc;
        n_tests++;
        if (bus.out_flat !== '0) begin
          n_fail++; $display("FAIL midrst_flat: got %h, want 0", bus.out_flat);
        end
      end else begin
        tick(1'b0, 1'b0, 0, 0, 0, 1'b0);
      end
      if (k > 5 && first < 0 && bus.out_valid === 1'b1) begin
        first = cyc - rel;
        n_tests++;
        if (bus.out_ch !== 4'd0) begin
          n_fail++; $display("FAIL midrst_first_ch: got %0d, want 0", bus.out_ch);
        end
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        m_out[e.ch] = e.val;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 4'(e.ch) || bus.out_flat !== exp_flat()) begin
          n_fail++;
          $display("FAIL midrst_sample cyc=%0d: valid=%b ch=%0d flat=%h, want valid=1 ch=%0d flat=%h",
                   cyc, bus.out_valid, bus.out_ch, bus.out_flat, e.ch, exp_flat());
        end
        if (k > 5) begin
          n_tests++;
          if (bus.out_flat[e.ch*OW +: OW] !== 12'd2048) begin
            n_fail++; $display("FAIL midrst_default ch=%0d: got %0d, want 2048", e.ch, bus.out_flat[e.ch*OW +: OW]);
          end
        end
      end else if (bus.out_valid !== 1'b0) begin
        n_tests++; n_fail++;
        $display("FAIL midrst_extra cyc=%0d: out_valid=%b ch=%0d, want none", cyc, bus.out_valid, bus.out_ch);
      end
    end
    n_tests++;
    if (first != 3) begin
      n_fail++; $display("FAIL midrst_latency: first out_valid after %0d edges, want 3", first);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_ignored_writes();
    test_sawtooth();
    test_triangle();
    test_square();
    test_sync_phase();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
